// File: rtl/lif_pkg.sv
// Shared FP16 types, field widths and constants for the LIF neuron and its adder.
// Input sanitising (NaN/Inf -> max, subnormal -> zero) lives here so every consumer treats operands alike.
package lif_pkg;

  typedef logic [15:0] fp16_t;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;

  localparam fp16_t FP16_ZERO = 16'h0000;
  localparam fp16_t FP16_ONE  = 16'h3C00;
  localparam fp16_t FP16_MAX  = 16'h7BFF;

  function automatic fp16_t fp16_sanitize(input fp16_t x);
    fp16_t r;
    r = x;
    if (x[14:10] == '1)
      r = FP16_MAX;
    else if (x[14:10] == '0)
      r = FP16_ZERO;
    return r;
  endfunction

endpackage

// File: rtl/fp16_add.sv
// Combinational FP16 add/subtract with flush-to-zero, truncation and saturation to FP16_MAX.
// The smaller operand is aligned into a wide field so the exact sum is formed before truncating.
module fp16_add
  import lif_pkg::*;
(
  input  fp16_t i_a,
  input  fp16_t i_b,
  input  logic  i_sub,
  output fp16_t o_sum
);

  fp16_t            w_a;
  fp16_t            w_b;
  fp16_t            w_big;
  fp16_t            w_small;
  logic             w_sign_b;
  logic             w_big_sign;
  logic             w_small_sign;
  logic             w_eff_sub;
  logic [EXP_W-1:0] w_exp_diff;
  logic [41:0]      w_big_ext;
  logic [41:0]      w_small_ext;
  logic [42:0]      w_raw;
  logic [42:0]      w_norm;
  logic [5:0]       w_lead;
  logic signed [7:0] w_exp_res;
  logic [32:0]      w_unused_bits;

  // Exponent difference never exceeds 29 for a non-zero operand, so 31 guard bits keep the sum exact.
  always_comb begin
    w_a          = fp16_sanitize(i_a);
    w_b          = fp16_sanitize(i_b);
    w_sign_b     = w_b[15] ^ i_sub;
    w_big        = w_a;
    w_big_sign   = w_a[15];
    w_small      = w_b;
    w_small_sign = w_sign_b;
    if (w_a[14:0] < w_b[14:0]) begin
      w_big        = w_b;
      w_big_sign   = w_sign_b;
      w_small      = w_a;
      w_small_sign = w_a[15];
    end
    w_eff_sub   = w_big_sign ^ w_small_sign;
    w_exp_diff  = w_big[14:10] - w_small[14:10];
    w_big_ext   = {(w_big[14:10] != '0), w_big[MAN_W-1:0], 31'd0};
    w_small_ext = {(w_small[14:10] != '0), w_small[MAN_W-1:0], 31'd0} >> w_exp_diff;
    if (w_eff_sub)
      w_raw = {1'b0, w_big_ext} - {1'b0, w_small_ext};
    else
      w_raw = {1'b0, w_big_ext} + {1'b0, w_small_ext};

    w_lead = '0;
    for (int k = 0; k < 43; k++) begin
      if (w_raw[k])
        w_lead = 6'(k);
    end
    w_norm        = w_raw << (6'd42 - w_lead);
    w_exp_res     = $signed({3'b000, w_big[14:10]}) + $signed({2'b00, w_lead}) - 8'sd41;
    w_unused_bits = {w_norm[42], w_norm[31:0]};

    if (w_raw == '0)
      o_sum = FP16_ZERO;
    else if (w_exp_res >= 8'sd31)
      o_sum = FP16_MAX;
    else if (w_exp_res <= 8'sd0)
      o_sum = FP16_ZERO;
    else
      o_sum = {w_big_sign, w_exp_res[4:0], w_norm[41:32]};
  end

endmodule

// File: rtl/modified_lif_neuron.sv
// Leaky integrate-and-fire neuron with FP16 membrane potential; one update per clock.
// Optional refractory period is enabled by defining LIF_REFRACTORY_EN.
module modified_lif_neuron
  import lif_pkg::*;
#(
  parameter fp16_t THRESHOLD      = 16'h4400,
  parameter fp16_t V_RESET        = 16'h0000,
  parameter int    LEAK_SHIFT     = 3,
  parameter int    REFRACT_CYCLES = 2
) (
  input  logic  clk,
  input  logic  reset,
  input  fp16_t input_current,
  output logic  fired
);

  localparam logic [EXP_W-1:0] LS = EXP_W'(LEAK_SHIFT);

  fp16_t r_v;
  logic  r_fired;
  fp16_t w_leak;
  fp16_t w_diff;
  fp16_t w_sum;
  fp16_t w_vnext;
  logic  w_fire;

`ifdef LIF_REFRACTORY_EN
  logic [7:0] r_refract;
`else
  localparam int unused_refract_cycles = REFRACT_CYCLES;
`endif

  // Multiplying by 2^-LEAK_SHIFT is an exponent decrement; small exponents flush to zero.
  always_comb begin
    w_leak = FP16_ZERO;
    if (r_v[14:10] > LS)
      w_leak = {r_v[15], r_v[14:10] - LS, r_v[MAN_W-1:0]};
  end

  fp16_add u_leak_sub (
    .i_a   (r_v),
    .i_b   (w_leak),
    .i_sub (1'b1),
    .o_sum (w_diff)
  );

  fp16_add u_integrate (
    .i_a   (w_diff),
    .i_b   (input_current),
    .i_sub (1'b0),
    .o_sum (w_sum)
  );

  assign w_vnext = w_sum[15] ? FP16_ZERO : w_sum;
  assign w_fire  = (w_vnext[14:0] >= THRESHOLD[14:0]);
  assign fired   = r_fired;

`ifdef LIF_REFRACTORY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v       <= V_RESET;
      r_fired   <= 1'b0;
      r_refract <= '0;
    end else if (r_refract != '0) begin
      r_v       <= V_RESET;
      r_fired   <= 1'b0;
      r_refract <= r_refract - 8'd1;
    end else if (w_fire) begin
      r_v       <= V_RESET;
      r_fired   <= 1'b1;
      r_refract <= 8'(REFRACT_CYCLES);
    end else begin
      r_v       <= w_vnext;
      r_fired   <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v     <= V_RESET;
      r_fired <= 1'b0;
    end else if (w_fire) begin
      r_v     <= V_RESET;
      r_fired <= 1'b1;
    end else begin
      r_v     <= w_vnext;
      r_fired <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_modified_lif_neuron.sv
// Self-checking bench for modified_lif_neuron against a real-valued reference model.
// Honours LIF_REFRACTORY_EN when the same macro is defined for the build.
module tb_modified_lif_neuron;
  import lif_pkg::*;

  localparam int  REFRACT    = 2;
  localparam int  LEAK_SHIFT = 3;
  localparam real THRESH     = 4.0;

  logic  clk;
  logic  reset;
  fp16_t input_current;
  logic  fired;

  int testsRun;
  int failCount;

  real  mV;
  int   mRefract;
  logic mFired;

  modified_lif_neuron dut (
    .clk           (clk),
    .reset         (reset),
    .input_current (input_current),
    .fired         (fired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  // Value an FP16 pattern stands for once NaN/Inf and subnormals are sanitised
  function automatic real toReal(input fp16_t x);
    int  e;
    real r;
    e = int'(x[14:10]);
    if (e == 31) return 65504.0;
    if (e == 0) return 0.0;
    r = (1.0 + real'(int'(x[9:0])) / 1024.0) * pow2(e - 15);
    return x[15] ? -r : r;
  endfunction

  // Truncating conversion of an exact real to FP16 with flush and saturation
  function automatic fp16_t toFp16(input real x);
    logic s;
    real  a;
    int   e;
    int   m;
    s = (x < 0.0);
    a = s ? -x : x;
    if (a < pow2(-14)) return 16'h0000;
    if (a >= pow2(16)) return 16'h7BFF;
    e = 15;
    while (a < pow2(e)) e--;
    m = int'($floor((a / pow2(e) - 1.0) * 1024.0));
    return {s, 5'(e + 15), 10'(m)};
  endfunction

  task automatic modelReset();
    mV       = 0.0;
    mRefract = 0;
    mFired   = 1'b0;
  endtask

  task automatic modelStep(input fp16_t cur);
    real leak;
    real d;
    real s;
`ifdef LIF_REFRACTORY_EN
    if (mRefract > 0) begin
      mRefract--;
      mV     = 0.0;
      mFired = 1'b0;
      return;
    end
`endif
    leak = (mV >= pow2(LEAK_SHIFT - 14)) ? mV * pow2(-LEAK_SHIFT) : 0.0;
    d    = toReal(toFp16(mV - leak));
    s    = toReal(toFp16(d + toReal(cur)));
    if (s < 0.0) s = 0.0;
    if (s >= THRESH) begin
      mV       = 0.0;
      mFired   = 1'b1;
      mRefract = REFRACT;
    end else begin
      mV     = s;
      mFired = 1'b0;
    end
  endtask

  task automatic step(input fp16_t cur);
    input_current = cur;
    @(posedge clk);
    #1;
    modelStep(cur);
  endtask

  task automatic doReset();
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    modelReset();
  endtask

  task automatic test_reset();
    input_current = 16'h4400;
    reset = 1'b0;
    #2;
    testsRun++;
    if (fired !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_fired: got %b expected 0", fired);
    end
    @(posedge clk); #1;
    testsRun++;
    if (dut.r_v !== 16'h0000) begin
      failCount++;
      $display("[TB] FAIL reset_v: got %h expected 0000", dut.r_v);
    end
    testsRun++;
    if (fired !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_hold_fired: got %b expected 0", fired);
    end
    reset = 1'b1;
    modelReset();
  endtask

  task automatic test_charge();
    fp16_t vTable[5] = '{16'h3C00, 16'h3F80, 16'h4148, 16'h429F, 16'h43CB};
    int period;
    logic expFire;
`ifdef LIF_REFRACTORY_EN
    period = 6 + REFRACT;
`else
    period = 6;
`endif
    doReset();
    for (int k = 0; k < 26; k++) begin
      step(16'h3C00);
      if (k < 5) begin
        testsRun++;
        if (dut.r_v !== vTable[k]) begin
          failCount++;
          $display("[TB] FAIL charge_v[%0d]: got %h expected %h", k, dut.r_v, vTable[k]);
        end
      end
      expFire = (k + 1 >= 6) && (((k + 1 - 6) % period) == 0);
      testsRun++;
      if (fired !== expFire) begin
        failCount++;
        $display("[TB] FAIL charge_fired[%0d]: got %b expected %b", k, fired, expFire);
      end
      testsRun++;
      if (dut.r_v !== toFp16(mV)) begin
        failCount++;
        $display("[TB] FAIL charge_model_v[%0d]: got %h expected %h", k, dut.r_v, toFp16(mV));
      end
    end
  endtask

  task automatic test_decay();
    fp16_t prevV;
    doReset();
    for (int k = 0; k < 5; k++) step(16'h3C00);
    prevV = dut.r_v;
    for (int k = 0; k < 20; k++) begin
      step(16'h0000);
      testsRun++;
      if (fired !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL decay_fired[%0d]: got %b expected 0", k, fired);
      end
      testsRun++;
      if (dut.r_v !== toFp16(mV) || (dut.r_v > prevV)) begin
        failCount++;
        $display("[TB] FAIL decay_v[%0d]: got %h expected %h", k, dut.r_v, toFp16(mV));
      end
      prevV = dut.r_v;
    end
  endtask

  task automatic test_continuous();
    logic expFire;
    doReset();
    for (int k = 0; k < 12; k++) begin
      step(16'h4400);
`ifdef LIF_REFRACTORY_EN
      expFire = ((k % (REFRACT + 1)) == 0);
`else
      expFire = 1'b1;
`endif
      testsRun++;
      if (fired !== expFire) begin
        failCount++;
        $display("[TB] FAIL continuous_fired[%0d]: got %b expected %b", k, fired, expFire);
      end
    end
  endtask

  task automatic test_negative();
    doReset();
    for (int k = 0; k < 8; k++) begin
      step(16'hBC00);
      testsRun++;
      if (dut.r_v !== 16'h0000 || fired !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL negative[%0d]: got v=%h fired=%b expected v=0000 fired=0", k, dut.r_v, fired);
      end
    end
  endtask

  task automatic test_reset_midcharge();
    doReset();
    for (int k = 0; k < 5; k++) step(16'h3C00);
    #3 reset = 1'b0;
    #1;
    testsRun++;
    if (dut.r_v !== 16'h0000 || fired !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midcharge_async: got v=%h fired=%b expected v=0000 fired=0", dut.r_v, fired);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    modelReset();
    for (int k = 0; k < 6; k++) step(16'h3C00);
    testsRun++;
    if (fired !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL pending_spike_setup: got %b expected 1", fired);
    end
    #3 reset = 1'b0;
    #1;
    testsRun++;
    if (fired !== 1'b0 || dut.r_v !== 16'h0000) begin
      failCount++;
      $display("[TB] FAIL pending_spike_cleared: got v=%h fired=%b expected v=0000 fired=0", dut.r_v, fired);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    modelReset();
    for (int k = 0; k < 6; k++) begin
      step(16'h3C00);
      testsRun++;
      if (fired !== (k == 5)) begin
        failCount++;
        $display("[TB] FAIL after_release_fired[%0d]: got %b expected %b", k, fired, (k == 5));
      end
    end
  endtask

  function automatic fp16_t randCurrent();
    logic       s;
    logic [4:0] e;
    logic [9:0] m;
    if ($urandom_range(0, 9) == 0) return 16'($urandom);
    s = ($urandom_range(0, 3) == 0);
    e = 5'($urandom_range(11, 17));
    m = 10'($urandom);
    return {s, e, m};
  endfunction

  task automatic test_random();
    fp16_t cur;
    doReset();
    for (int k = 0; k < 300; k++) begin
      cur = randCurrent();
      step(cur);
      testsRun++;
      if (fired !== mFired) begin
        failCount++;
        $display("[TB] FAIL random_fired[%0d] in=%h: got %b expected %b", k, cur, fired, mFired);
      end
      testsRun++;
      if (dut.r_v !== toFp16(mV)) begin
        failCount++;
        $display("[TB] FAIL random_v[%0d] in=%h: got %h expected %h", k, cur, dut.r_v, toFp16(mV));
      end
    end
  endtask

  initial begin
    testsRun      = 0;
    failCount     = 0;
    reset         = 1'b0;
    input_current = 16'h0000;
    modelReset();
    test_reset();
    test_charge();
    test_decay();
    test_continuous();
    test_negative();
    test_reset_midcharge();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
